// File: rtl/uart_oversampled_receiver_if.sv
// Byte delivery channel between the UART receiver and its consumer.
// The master side presents a received byte and its flags; the slave side accepts it with ready.
interface uart_oversampled_receiver_if;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       parity_error;
    logic       frame_error;

    modport master (
        output data_out,
        output valid,
        output parity_error,
        output frame_error,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        input  parity_error,
        input  frame_error,
        output ready
    );
endinterface

// File: rtl/uart_oversampled_receiver.sv
// Oversampling UART receiver: 8 data bits LSB first, odd parity, one stop bit.
// Completed bytes are held in a one-entry valid/ready register until the consumer takes them.
module uart_oversampled_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               baud_tick,
    input  logic                               rxd,
    uart_oversampled_receiver_if.master        rx_bus,
    output logic                               overrun,
    output logic                               busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t        state_r;
    logic [TW-1:0] tick_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          perr_r;
    logic          ferr_r;
    logic          done_r;
    logic          busy_r;
    logic          sync_r;
    logic          rxd_s_r;
    logic [7:0]    data_out_r;
    logic          valid_r;
    logic          parity_error_r;
    logic          frame_error_r;
    logic          overrun_r;

    // Returns 1 when data plus parity bit do not contain an odd number of ones.
    function automatic logic odd_parity_error(input logic [7:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r  <= 1'b1;
            rxd_s_r <= 1'b1;
        end else begin
            sync_r  <= rxd;
            rxd_s_r <= sync_r;
        end
    end

    // Frame FSM: advances only on baud ticks; done_r pulses for one clock when a byte completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (baud_tick) begin
                case (state_r)
                    IDLE: begin
                        if (!rxd_s_r) begin
                            state_r    <= START;
                            tick_cnt_r <= '0;
                            busy_r     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt_r == HALF_LAST) begin
                            tick_cnt_r <= '0;
                            bit_cnt_r  <= 3'd0;
                            if (!rxd_s_r) begin
                                state_r <= DATA;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt_r == BIT_LAST) begin
                            tick_cnt_r         <= '0;
                            shift_r[bit_cnt_r] <= rxd_s_r;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= PARITY;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (tick_cnt_r == BIT_LAST) begin
                            tick_cnt_r <= '0;
                            perr_r     <= odd_parity_error(shift_r, rxd_s_r);
                            state_r    <= STOP;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                    STOP: begin
                        if (tick_cnt_r == BIT_LAST) begin
                            tick_cnt_r <= '0;
                            ferr_r     <= ~rxd_s_r;
                            done_r     <= 1'b1;
                            if (rxd_s_r) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= WAIT_HIGH;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                    WAIT_HIGH: begin
                        // A break keeps the line low; wait for idle before hunting for a new start.
                        if (rxd_s_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        tick_cnt_r <= '0;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // One-entry holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_r     <= 8'h00;
            valid_r        <= 1'b0;
            parity_error_r <= 1'b0;
            frame_error_r  <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (done_r) begin
                if (!valid_r || rx_bus.ready) begin
                    data_out_r     <= shift_r;
                    parity_error_r <= perr_r;
                    frame_error_r  <= ferr_r;
                    valid_r        <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && rx_bus.ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign rx_bus.data_out     = data_out_r;
    assign rx_bus.valid        = valid_r;
    assign rx_bus.parity_error = parity_error_r;
    assign rx_bus.frame_error  = frame_error_r;
    assign overrun             = overrun_r;
    assign busy                = busy_r;

endmodule

// File: tb/tb_uart_oversampled_receiver.sv
// Directed bench for uart_oversampled_receiver: a table of frames plus hand-written
// sequences for overrun, glitch rejection, mid-frame reset and a slowed baud_tick.
module tb_uart_oversampled_receiver;

    localparam int OS = 16;
    // Clocks from driving the start edge (just after an edge) to valid being high with
    // baud_tick every clock: 2 synchronizer flops + 1 edge to see it, frame ticks, +1 to load.
    localparam int LAT1 = 3 + OS / 2 + 10 * OS + 1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic clock;
    logic reset;
    logic baud_tick;
    logic rxd;
    logic overrun;
    logic busy;

    uart_oversampled_receiver_if bus ();

    uart_oversampled_receiver #(.OVERSAMPLE(OS)) dut (
        .clock     (clock),
        .reset     (reset),
        .baud_tick (baud_tick),
        .rxd       (rxd),
        .rx_bus    (bus),
        .overrun   (overrun),
        .busy      (busy)
    );

    int         checks;
    int         errors;
    int         cyc;
    int         tick_div;
    int         fall_cyc;
    int         rise_cyc;
    int         rise_cnt;
    int         ovr_cnt;
    logic [7:0] acc_q[$];
    vec_t       vecs[7];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        int tick_phase;
        tick_phase = 0;
        baud_tick  = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            baud_tick = (tick_phase == 0);
            if (tick_phase >= tick_div - 1) tick_phase = 0;
            else tick_phase++;
        end
    end

    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        rise_cyc   = 0;
        rise_cnt   = 0;
        ovr_cnt    = 0;
        forever begin
            @(negedge clock);
            if (bus.valid && !prev_valid) begin
                rise_cyc = cyc;
                rise_cnt++;
            end
            if (bus.valid && bus.ready) acc_q.push_back(bus.data_out);
            if (overrun) ovr_cnt++;
            prev_valid = bus.valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int div);
        rxd = b;
        step(OS * div);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int div);
        fall_cyc = cyc;
        drive_bit(1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(d[i], div);
        drive_bit(p, div);
        drive_bit(s, div);
    endtask

    // Starts a frame, abandons it with reset halfway through data bit 4, then sends 0x5A.
    task automatic reset_then_5a(input int div);
        int base;
        int lo;
        int hi;
        bus.ready = 1'b1;
        drive_bit(1'b0, div);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, div);
        rxd = 1'b0;
        step(OS / 2 * div);
        check("busy_in_data_bit4", busy, 1'b1);
        reset = 1'b1;
        rxd   = 1'b1;
        step(2);
        reset = 1'b0;
        check("busy_after_reset", busy, 1'b0);
        check("valid_after_reset", bus.valid, 1'b0);
        step(2 * OS * div);
        base = acc_q.size();
        send_frame(8'h5A, 1'b1, 1'b1, div);
        step(OS * div);
        check("reset_frame_count", acc_q.size() - base, 1);
        if (acc_q.size() > base) check("reset_frame_data", acc_q[base], 8'h5A);
        // start edge lands on a tick between 3 and 3+div-1 edges after rxd falls
        lo = 3 + (OS / 2 + 10 * OS) * div + 1;
        hi = lo + div - 1;
        checks++;
        if (rise_cyc - fall_cyc < lo || rise_cyc - fall_cyc > hi) begin
            errors++;
            $display("FAIL reset_frame_latency: got %0d, expected %0d..%0d", rise_cyc - fall_cyc, lo, hi);
        end
        bus.ready = 1'b0;
    endtask

    initial begin
        int ovr_base;
        int rise_base;
        int base;
        checks    = 0;
        errors    = 0;
        tick_div  = 1;
        reset     = 1'b1;
        rxd       = 1'b1;
        bus.ready = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1};

        step(4);
        check("reset_valid", bus.valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_data", bus.data_out, 8'h00);
        check("reset_perr", bus.parity_error, 1'b0);
        check("reset_ferr", bus.frame_error, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        reset = 1'b0;
        step(OS);

        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].par, vecs[k].stp, 1);
            check($sformatf("v%0d_valid", k), bus.valid, 1'b1);
            check($sformatf("v%0d_data", k), bus.data_out, vecs[k].exp_data);
            check($sformatf("v%0d_perr", k), bus.parity_error, vecs[k].exp_perr);
            check($sformatf("v%0d_ferr", k), bus.frame_error, vecs[k].exp_ferr);
            check($sformatf("v%0d_latency", k), rise_cyc - fall_cyc, LAT1);
            if (!vecs[k].stp) begin
                step(40);
                check($sformatf("v%0d_busy_break", k), busy, 1'b1);
                rxd = 1'b1;
                step(8);
                check($sformatf("v%0d_busy_idle", k), busy, 1'b0);
            end
            bus.ready = 1'b1;
            step(1);
            bus.ready = 1'b0;
            check($sformatf("v%0d_handshake", k), bus.valid, 1'b0);
            step(OS);
        end

        // Short low glitch while idle must be rejected at the start-bit midpoint.
        rise_base = rise_cnt;
        rxd = 1'b0;
        step(5);
        check("glitch_busy_start", busy, 1'b1);
        rxd = 1'b1;
        step(30);
        check("glitch_busy_idle", busy, 1'b0);
        check("glitch_no_valid", rise_cnt - rise_base, 0);

        // Overrun: second byte dropped while the first is unconsumed.
        ovr_base = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b1, 1);
        check("ovr_first_data", bus.data_out, 8'h11);
        send_frame(8'h22, 1'b1, 1'b1, 1);
        check("ovr_held_data", bus.data_out, 8'h11);
        check("ovr_held_valid", bus.valid, 1'b1);
        check("ovr_pulses", ovr_cnt - ovr_base, 1);
        bus.ready = 1'b1;
        step(1);
        check("ovr_release_valid", bus.valid, 1'b0);
        base = acc_q.size();
        ovr_base = ovr_cnt;
        send_frame(8'h33, 1'b1, 1'b1, 1);
        send_frame(8'h44, 1'b1, 1'b1, 1);
        step(4);
        check("b2b_count", acc_q.size() - base, 2);
        if (acc_q.size() >= base + 2) begin
            check("b2b_first", acc_q[base], 8'h33);
            check("b2b_second", acc_q[base + 1], 8'h44);
        end
        check("b2b_no_overrun", ovr_cnt - ovr_base, 0);
        bus.ready = 1'b0;
        step(OS);

        reset_then_5a(1);
        tick_div = 4;
        step(8);
        reset_then_5a(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
